// File: rtl/level_referee.sv
// Level referee: counts coins, the level timer and lives, and hands
// level-passed or game-lost requests to the game controller.
// Optional feature: define REFEREE_BONUS_TIME_EN so each coin adds two seconds.
module level_referee (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] gameStatus,
    input  logic [2:0] level,
    input  logic       world,
    input  logic       tick,
    input  logic       coinHit,
    input  logic       hazardHit,
    output logic       levelPassed,
    output logic       lose,
    output logic [3:0] coins,
    output logic [6:0] timeLeft,
    output logic [1:0] lives
);

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        PASS_HOLD,
        LOSE_HOLD,
        WAIT_RESUME,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic       levelPassed_q, levelPassed_d;
    logic       lose_q, lose_d;
    logic [3:0] coins_q, coins_d;
    logic [6:0] timeLeft_q, timeLeft_d;
    logic [1:0] lives_q, lives_d;

    logic [6:0] limit;
    logic [3:0] target;
    logic [3:0] coinsInc;
    logic [6:0] timeDec;
    logic [6:0] timeNext;
    logic       fatal;
    logic       reachTarget;
    logic       expire;

    assign limit    = 7'd60 - {2'b00, level, 2'b00} - (world ? 7'd10 : 7'd0);
    assign target   = 4'd4 + {1'b0, level};
    assign coinsInc = (coins_q == 4'd15) ? 4'd15 : coins_q + 4'd1;
    assign timeDec  = (tick && timeLeft_q != 7'd0) ? timeLeft_q - 7'd1 : timeLeft_q;

`ifdef REFEREE_BONUS_TIME_EN
    // Bonus is added after the tick decrement so coin plus tick nets +1.
    assign timeNext = !coinHit ? timeDec :
                      (timeDec > 7'd97) ? 7'd99 : timeDec + 7'd2;
`else
    assign timeNext = timeDec;
`endif

    assign fatal       = hazardHit && (lives_q <= 2'd1);
    assign reachTarget = coinHit && (coinsInc >= target);
    assign expire      = tick && (timeLeft_q != 7'd0) && (timeNext == 7'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            levelPassed_q <= 1'b0;
            lose_q        <= 1'b0;
            coins_q       <= 4'd0;
            timeLeft_q    <= 7'd0;
            lives_q       <= 2'd3;
        end else begin
            state_q       <= state_d;
            levelPassed_q <= levelPassed_d;
            lose_q        <= lose_d;
            coins_q       <= coins_d;
            timeLeft_q    <= timeLeft_d;
            lives_q       <= lives_d;
        end
    end

    // Priority inside PLAY: fatal hazard, then target coin, then time expiry.
    always_comb begin
        state_d       = state_q;
        levelPassed_d = levelPassed_q;
        lose_d        = lose_q;
        coins_d       = coins_q;
        timeLeft_d    = timeLeft_q;
        lives_d       = lives_q;

        case (state_q)
            IDLE, WAIT_RESUME: begin
                if (gameStatus == 3'd0) begin
                    coins_d    = 4'd0;
                    timeLeft_d = limit;
                    state_d    = PLAY;
                end else if (state_q == WAIT_RESUME && gameStatus == 3'd3) begin
                    state_d = DONE;
                end
            end
            PLAY: begin
                if (hazardHit && lives_q != 2'd0) begin
                    lives_d = lives_q - 2'd1;
                end
                if (fatal) begin
                    lose_d  = 1'b1;
                    state_d = LOSE_HOLD;
                end else begin
                    if (coinHit) begin
                        coins_d = coinsInc;
                    end
                    timeLeft_d = timeNext;
                    if (reachTarget) begin
                        state_d = PASS_HOLD;
                    end else if (expire) begin
                        lose_d  = 1'b1;
                        state_d = LOSE_HOLD;
                    end
                end
            end
            PASS_HOLD: begin
                if (gameStatus == 3'd1 || gameStatus == 3'd2) begin
                    levelPassed_d = 1'b0;
                    state_d       = WAIT_RESUME;
                end else begin
                    levelPassed_d = 1'b1;
                end
            end
            LOSE_HOLD: begin
                if (gameStatus == 3'd4) begin
                    lose_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign levelPassed = levelPassed_q;
    assign lose        = lose_q;
    assign coins       = coins_q;
    assign timeLeft    = timeLeft_q;
    assign lives       = lives_q;

endmodule
